// File: rtl/bp_fe_icache_replay_queue_pkg.sv
// Shared types for the I$ replay queue: default widths, result classification
// and the entry-struct declaration macro.
`ifndef BP_FE_ICACHE_REPLAY_QUEUE_PKG_SV
`define BP_FE_ICACHE_REPLAY_QUEUE_PKG_SV

`define DECLARE_BP_FE_ICACHE_REPLAY_ENTRY_S(vaddr_width_mp, ptag_width_mp) \
    typedef struct packed {                                                  \
        logic                      uncached;                                 \
        logic [vaddr_width_mp-1:0] vaddr;                                    \
        logic [ptag_width_mp-1:0]  ptag;                                     \
    } bp_fe_icache_replay_entry_s

package bp_fe_icache_replay_queue_pkg;

    localparam int default_vaddr_width_lp    = 39;
    localparam int default_ptag_width_lp     = 28;
    localparam int default_instr_width_lp    = 32;
    localparam int default_els_lp            = 8;
    localparam int default_miss_cnt_width_lp = 16;

    typedef enum logic [1:0] {
        e_ret_none = 2'd0,
        e_ret_hit  = 2'd1,
        e_ret_miss = 2'd2
    } ret_kind_e;

    // What the TV stage is presenting this cycle.
    function automatic ret_kind_e classify_ret(input logic data_v, input logic miss);
        if (!data_v) begin
            return e_ret_none;
        end
        return miss ? e_ret_miss : e_ret_hit;
    endfunction

endpackage

`endif

// File: rtl/bp_fe_icache_replay_queue_if.sv
// Request, cache and consumer signals of the replay queue bundled as one
// interface; master is the queue, slave is its environment.
interface bp_fe_icache_replay_queue_if
    import bp_fe_icache_replay_queue_pkg::*;
#(
    parameter int vaddr_width_p    = default_vaddr_width_lp,
    parameter int ptag_width_p     = default_ptag_width_lp,
    parameter int instr_width_p    = default_instr_width_lp,
    parameter int miss_cnt_width_p = default_miss_cnt_width_lp
);

    logic [vaddr_width_p-1:0]    vaddr_i;
    logic [ptag_width_p-1:0]     ptag_i;
    logic                        uncached_i;
    logic                        v_i;
    logic                        ready_o;

    logic [vaddr_width_p-1:0]    icache_vaddr_o;
    logic                        icache_v_o;
    logic                        icache_yumi_i;
    logic [ptag_width_p-1:0]     ptag_o;
    logic                        ptag_v_o;
    logic                        ptag_uncached_o;
    logic                        poison_o;

    logic [vaddr_width_p-1:0]    cache_vaddr_i;
    logic [instr_width_p-1:0]    cache_data_i;
    logic                        cache_data_v_i;
    logic                        cache_miss_i;
    logic                        cache_data_yumi_o;

    logic [vaddr_width_p-1:0]    vaddr_o;
    logic [instr_width_p-1:0]    data_o;
    logic                        v_o;
    logic                        yumi_i;

    logic [miss_cnt_width_p-1:0] miss_cnt_o;
    logic                        order_err_o;

    modport master (
        input  vaddr_i, ptag_i, uncached_i, v_i,
        input  icache_yumi_i,
        input  cache_vaddr_i, cache_data_i, cache_data_v_i, cache_miss_i,
        input  yumi_i,
        output ready_o,
        output icache_vaddr_o, icache_v_o, ptag_o, ptag_v_o, ptag_uncached_o, poison_o,
        output cache_data_yumi_o,
        output vaddr_o, data_o, v_o,
        output miss_cnt_o, order_err_o
    );

    modport slave (
        output vaddr_i, ptag_i, uncached_i, v_i,
        output icache_yumi_i,
        output cache_vaddr_i, cache_data_i, cache_data_v_i, cache_miss_i,
        output yumi_i,
        input  ready_o,
        input  icache_vaddr_o, icache_v_o, ptag_o, ptag_v_o, ptag_uncached_o, poison_o,
        input  cache_data_yumi_o,
        input  vaddr_o, data_o, v_o,
        input  miss_cnt_o, order_err_o
    );

endinterface

// File: rtl/bp_fe_icache_replay_queue_dff_reset.sv
// Plain register with synchronous active-high clear; holds the TL-stage
// {valid, uncached, ptag} of the replay queue.
module bp_fe_icache_replay_queue_dff_reset #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_fe_icache_replay_queue.sv
// In-order request queue feeding the I$ TL/TV pipeline; entries stay until
// their data is consumed, and a TV miss rewinds issue back to the oldest entry.
module bp_fe_icache_replay_queue
    import bp_fe_icache_replay_queue_pkg::*;
#(
    parameter int vaddr_width_p    = default_vaddr_width_lp,
    parameter int ptag_width_p     = default_ptag_width_lp,
    parameter int instr_width_p    = default_instr_width_lp,
    parameter int els_p            = default_els_lp,
    parameter int miss_cnt_width_p = default_miss_cnt_width_lp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_fe_icache_replay_queue_if.master io
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;
    localparam int tl_width_lp  = ptag_width_p + 2;

    `DECLARE_BP_FE_ICACHE_REPLAY_ENTRY_S(vaddr_width_p, ptag_width_p);

    bp_fe_icache_replay_entry_s  entry_q [els_p];
    bp_fe_icache_replay_entry_s  enq_entry;
    bp_fe_icache_replay_entry_s  issue_entry;
    logic [vaddr_width_p-1:0]    retire_vaddr;

    logic [ptr_width_lp-1:0]     wptr_q, wptr_d;
    logic [ptr_width_lp-1:0]     iptr_q, iptr_d;
    logic [ptr_width_lp-1:0]     rptr_q, rptr_d;
    logic [lg_els_lp-1:0]        widx, iidx, ridx;

    logic [miss_cnt_width_p-1:0] miss_cnt_q, miss_cnt_d;
    logic                        order_err_q, order_err_d;
    logic [tl_width_lp-1:0]      tl_d, tl_q;

    ret_kind_e                   ret_kind;
    logic                        full, pending, enq, issue, retire;
    logic                        hit, miss_now, order_mismatch;

    assign widx = wptr_q[lg_els_lp-1:0];
    assign iidx = iptr_q[lg_els_lp-1:0];
    assign ridx = rptr_q[lg_els_lp-1:0];

    // Wrap bits disambiguate full from empty when the index bits coincide.
    assign full    = (widx == ridx) && (wptr_q[lg_els_lp] != rptr_q[lg_els_lp]);
    assign pending = (iptr_q != wptr_q);

    assign ret_kind = classify_ret(io.cache_data_v_i, io.cache_miss_i);
    assign hit      = (ret_kind == e_ret_hit);
    assign miss_now = (ret_kind == e_ret_miss);

    assign enq_entry    = {io.uncached_i, io.vaddr_i, io.ptag_i};
    assign issue_entry  = entry_q[iidx];
    assign retire_vaddr = entry_q[ridx].vaddr;

    assign enq    = io.v_i & ~full;
    assign issue  = io.icache_v_o & io.icache_yumi_i;
    assign retire = hit & io.yumi_i;

    // The TV stage always holds the entry at the retire pointer.
    assign order_mismatch = io.cache_data_v_i & (io.cache_vaddr_i != retire_vaddr);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            entry_q[widx] <= enq_entry;
        end
    end

    always_comb begin
        wptr_d      = wptr_q;
        iptr_d      = iptr_q;
        rptr_d      = rptr_q;
        miss_cnt_d  = miss_cnt_q;
        order_err_d = order_err_q | order_mismatch;

        if (enq) begin
            wptr_d = wptr_q + ptr_width_lp'(1);
        end
        if (retire) begin
            rptr_d = rptr_q + ptr_width_lp'(1);
        end
        if (miss_now) begin
            iptr_d = rptr_q;
            if (~&miss_cnt_q) begin
                miss_cnt_d = miss_cnt_q + miss_cnt_width_p'(1);
            end
        end else if (issue) begin
            iptr_d = iptr_q + ptr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q      <= '0;
            iptr_q      <= '0;
            rptr_q      <= '0;
            miss_cnt_q  <= '0;
            order_err_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            iptr_q      <= iptr_d;
            rptr_q      <= rptr_d;
            miss_cnt_q  <= miss_cnt_d;
            order_err_q <= order_err_d;
        end
    end

    // TL register is a one-cycle echo of the issue; anything else clears it.
    assign tl_d = issue ? {1'b1, issue_entry.uncached, issue_entry.ptag} : '0;

    bp_fe_icache_replay_queue_dff_reset #(
        .width_p (tl_width_lp)
    ) tl_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (tl_d),
        .data_o  (tl_q)
    );

    assign io.ready_o           = ~full;
    assign io.icache_vaddr_o    = issue_entry.vaddr;
    assign io.icache_v_o        = pending & ~miss_now;
    assign io.ptag_v_o          = tl_q[tl_width_lp-1];
    assign io.ptag_uncached_o   = tl_q[ptag_width_p];
    assign io.ptag_o            = tl_q[ptag_width_p-1:0];
    assign io.poison_o          = miss_now & io.ptag_v_o;
    assign io.cache_data_yumi_o = io.cache_data_v_i & (io.cache_miss_i | io.yumi_i);
    assign io.v_o               = hit;
    assign io.vaddr_o           = io.cache_vaddr_i;
    assign io.data_o            = io.cache_data_i;
    assign io.miss_cnt_o        = miss_cnt_q;
    assign io.order_err_o       = order_err_q;

endmodule

// File: tb/tb_bp_fe_icache_replay_queue.sv
// Bench for the I$ replay queue: a two-stage cache model drives the TL/TV
// side and a scoreboard of enqueued vaddrs checks in-order retirement.
module tb_bp_fe_icache_replay_queue;

    localparam int VW  = 39;
    localparam int PW  = 28;
    localparam int IW  = 32;
    localparam int ELS = 8;
    localparam int MW  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_fe_icache_replay_queue_if #(
        .vaddr_width_p(VW), .ptag_width_p(PW), .instr_width_p(IW), .miss_cnt_width_p(MW)
    ) io ();

    bp_fe_icache_replay_queue #(
        .vaddr_width_p(VW), .ptag_width_p(PW), .instr_width_p(IW),
        .els_p(ELS), .miss_cnt_width_p(MW)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (io)
    );

    int checks = 0;
    int errors = 0;

    // cache model state
    logic          tl_v, tv_v, tv_miss;
    logic [VW-1:0] tl_vaddr, tv_vaddr;
    logic          prev_issued;
    logic [VW-1:0] prev_vaddr;
    logic          accept_en;
    int unsigned   yumi_pct, miss_pct;
    logic [VW-1:0] miss_once[$];

    // scoreboard and observations
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] iss_log[$];
    int            exp_miss_cnt;
    int            retired_cnt;
    logic          last_enq, last_retire, last_ready, saw_poison;

    function automatic logic [PW-1:0] ptag_of(input logic [VW-1:0] va);
        return PW'(va >> 2) ^ 28'h00A_5C3;
    endfunction

    function automatic logic [IW-1:0] data_of(input logic [VW-1:0] va);
        return IW'(va) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic decide_miss(input logic [VW-1:0] va);
        for (int i = 0; i < miss_once.size(); i++) begin
            if (miss_once[i] == va) begin
                miss_once.delete(i);
                return 1'b1;
            end
        end
        return ($urandom_range(99) < miss_pct);
    endfunction

    // One clock: drive cache/consumer inputs after negedge, check, then advance the model.
    task automatic cycle();
        logic          tv_free, enq, issued, retire, miss;
        logic [VW-1:0] iss_vaddr, exp_va;
        io.cache_data_v_i = tv_v;
        io.cache_miss_i   = tv_v & tv_miss;
        io.cache_vaddr_i  = tv_vaddr;
        io.cache_data_i   = data_of(tv_vaddr);
        io.yumi_i         = ($urandom_range(99) < yumi_pct);
        #1;
        tv_free = !tv_v || io.cache_data_yumi_o;
        io.icache_yumi_i = accept_en && io.icache_v_o && (tv_free || !tl_v);
        #1;
        enq       = io.v_i && io.ready_o;
        issued    = io.icache_v_o && io.icache_yumi_i;
        iss_vaddr = io.icache_vaddr_o;
        retire    = io.v_o && io.yumi_i;
        miss      = tv_v && tv_miss;

        checks++;
        if (io.ptag_v_o !== prev_issued) begin
            errors++;
            $display("FAIL ptag_v: got %b want %b", io.ptag_v_o, prev_issued);
        end
        if (prev_issued) begin
            checks++;
            if (io.ptag_o !== ptag_of(prev_vaddr) || io.ptag_uncached_o !== prev_vaddr[3]) begin
                errors++;
                $display("FAIL ptag: got %h/%b want %h/%b", io.ptag_o, io.ptag_uncached_o,
                         ptag_of(prev_vaddr), prev_vaddr[3]);
            end
        end
        checks++;
        if (io.poison_o !== (miss && prev_issued)) begin
            errors++;
            $display("FAIL poison: got %b want %b", io.poison_o, miss && prev_issued);
        end
        checks++;
        if (io.v_o !== (tv_v && !tv_miss) ||
            io.cache_data_yumi_o !== (tv_v && (tv_miss || io.yumi_i))) begin
            errors++;
            $display("FAIL v_yumi: got v_o=%b cache_yumi=%b want %b/%b", io.v_o, io.cache_data_yumi_o,
                     tv_v && !tv_miss, tv_v && (tv_miss || io.yumi_i));
        end
        checks++;
        if (io.miss_cnt_o !== MW'(exp_miss_cnt)) begin
            errors++;
            $display("FAIL miss_cnt: got %0d want %0d", io.miss_cnt_o, exp_miss_cnt);
        end
        if (io.poison_o) saw_poison = 1'b1;
        if (retire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_extra: got vaddr %h want none", io.vaddr_o);
            end else begin
                exp_va = exp_q.pop_front();
                if (io.vaddr_o !== exp_va || io.data_o !== data_of(exp_va)) begin
                    errors++;
                    $display("FAIL retire_order: got %h/%h want %h/%h", io.vaddr_o, io.data_o,
                             exp_va, data_of(exp_va));
                end
            end
            retired_cnt++;
            $display("retire vaddr=%h data=%h", io.vaddr_o, io.data_o);
        end
        if (enq) exp_q.push_back(io.vaddr_i);
        if (issued) iss_log.push_back(iss_vaddr);
        last_enq    = enq;
        last_retire = retire;
        last_ready  = io.ready_o;

        @(posedge clk);
        if (miss) begin
            exp_miss_cnt++;
            tv_v = 1'b0;
            tl_v = 1'b0;
        end else if (tv_free) begin
            tv_v    = tl_v;
            tv_miss = 1'b0;
            if (tl_v) begin
                tv_vaddr = tl_vaddr;
                tv_miss  = decide_miss(tl_vaddr);
            end
            tl_v     = issued;
            tl_vaddr = iss_vaddr;
        end else if (issued) begin
            tl_v     = 1'b1;
            tl_vaddr = iss_vaddr;
        end
        prev_issued = issued;
        prev_vaddr  = iss_vaddr;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [VW-1:0] va);
        io.v_i        = 1'b1;
        io.vaddr_i    = va;
        io.ptag_i     = ptag_of(va);
        io.uncached_i = va[3];
        cycle();
        io.v_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        io.v_i = 1'b0;
        while ((exp_q.size() != 0 || tv_v || tl_v) && n < 1000) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d outstanding want 0", name, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        io.v_i            = 1'b0;
        io.vaddr_i        = '0;
        io.ptag_i         = '0;
        io.uncached_i     = 1'b0;
        io.icache_yumi_i  = 1'b0;
        io.cache_data_v_i = 1'b0;
        io.cache_miss_i   = 1'b0;
        io.cache_vaddr_i  = '0;
        io.cache_data_i   = '0;
        io.yumi_i         = 1'b0;
        tl_v = 1'b0; tv_v = 1'b0; tv_miss = 1'b0;
        tl_vaddr = '0; tv_vaddr = '0;
        prev_issued = 1'b0; prev_vaddr = '0;
        exp_q.delete();
        miss_once.delete();
        exp_miss_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({io.ready_o, io.icache_v_o, io.ptag_v_o, io.poison_o, io.v_o,
             io.cache_data_yumi_o, io.order_err_o} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000000", {io.ready_o, io.icache_v_o, io.ptag_v_o,
                     io.poison_o, io.v_o, io.cache_data_yumi_o, io.order_err_o});
        end
        checks++;
        if (io.miss_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_miss_cnt: got %0d want 0", io.miss_cnt_o);
        end
    endtask

    task automatic test_hits();
        int base = retired_cnt;
        accept_en = 1'b1; yumi_pct = 100; miss_pct = 0;
        drive_req(39'h1000);
        checks++;
        if (io.icache_v_o !== 1'b1) begin
            errors++;
            $display("FAIL enq_to_issue: got icache_v_o=%b want 1", io.icache_v_o);
        end
        drive_req(39'h1004);
        drive_req(39'h1008);
        drain("hits");
        checks++;
        if (retired_cnt - base != 3 || io.miss_cnt_o !== '0) begin
            errors++;
            $display("FAIL hits_count: got %0d retired miss_cnt=%0d want 3/0", retired_cnt - base, io.miss_cnt_o);
        end
    endtask

    task automatic test_miss();
        logic [VW-1:0] want[4];
        want[0] = 39'h2000; want[1] = 39'h2004; want[2] = 39'h2000; want[3] = 39'h2004;
        accept_en = 1'b1; yumi_pct = 100; miss_pct = 0;
        iss_log.delete();
        saw_poison = 1'b0;
        miss_once.push_back(39'h2000);
        drive_req(39'h2000);
        drive_req(39'h2004);
        drain("miss");
        checks++;
        if (saw_poison !== 1'b1 || io.miss_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL miss_poison: got poison_seen=%b miss_cnt=%0d want 1/1", saw_poison, io.miss_cnt_o);
        end
        checks++;
        if (iss_log.size() != 4) begin
            errors++;
            $display("FAIL reissue_count: got %0d issues want 4", iss_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (iss_log[i] !== want[i]) begin
                    errors++;
                    $display("FAIL reissue_order[%0d]: got %h want %h", i, iss_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        int n = 0;
        accept_en = 1'b0; yumi_pct = 100; miss_pct = 0;
        for (int i = 0; i < ELS; i++) drive_req(39'h6000 + VW'(4 * i));
        checks++;
        if (io.ready_o !== 1'b0 || exp_q.size() != ELS) begin
            errors++;
            $display("FAIL full_ready: got ready=%b stored=%0d want 0/%0d", io.ready_o, exp_q.size(), ELS);
        end
        accept_en = 1'b1;
        last_retire = 1'b0;
        while (!last_retire && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (!last_retire || last_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_retire_cycle: got retired=%b ready=%b want 1/0", last_retire, last_ready);
        end
        checks++;
        if (io.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_after_retire: got ready=%b want 1", io.ready_o);
        end
        drain("full");
    endtask

    task automatic test_wrap();
        int sent = 0;
        int n = 0;
        int base = retired_cnt;
        accept_en = 1'b1; yumi_pct = 60; miss_pct = 15;
        while ((sent < 20 || exp_q.size() != 0 || tv_v || tl_v) && n < 3000) begin
            if (sent < 20 && $urandom_range(3) != 0) begin
                drive_req(39'h4000 + VW'(4 * sent));
                if (last_enq) sent++;
            end else begin
                cycle();
            end
            n++;
        end
        checks++;
        if (sent != 20 || retired_cnt - base != 20 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap: got sent=%0d retired=%0d left=%0d want 20/20/0", sent, retired_cnt - base, exp_q.size());
        end
        checks++;
        if (io.order_err_o !== 1'b0) begin
            errors++;
            $display("FAIL order_clean: got order_err=%b want 0", io.order_err_o);
        end
    endtask

    task automatic test_order_err();
        accept_en = 1'b0; yumi_pct = 0; miss_pct = 0;
        drive_req(39'h3000);
        tv_v = 1'b1; tv_vaddr = 39'h3004; tv_miss = 1'b0;
        cycle();
        checks++;
        if (io.order_err_o !== 1'b1) begin
            errors++;
            $display("FAIL order_err_set: got %b want 1", io.order_err_o);
        end
        tv_v = 1'b0;
        cycle();
        cycle();
        checks++;
        if (io.order_err_o !== 1'b1) begin
            errors++;
            $display("FAIL order_err_sticky: got %b want 1", io.order_err_o);
        end
    endtask

    task automatic test_reset_mid();
        accept_en = 1'b0; yumi_pct = 0; miss_pct = 0;
        for (int i = 0; i < 4; i++) drive_req(39'h7000 + VW'(4 * i));
        checks++;
        if (io.icache_v_o !== 1'b1 || io.miss_cnt_o === '0) begin
            errors++;
            $display("FAIL pre_reset: got icache_v=%b miss_cnt=%0d want 1/nonzero", io.icache_v_o, io.miss_cnt_o);
        end
        apply_reset();
        checks++;
        if (io.ready_o !== 1'b1 || io.icache_v_o !== 1'b0 || io.miss_cnt_o !== '0 ||
            io.ptag_v_o !== 1'b0 || io.order_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b icache_v=%b miss_cnt=%0d ptag_v=%b order_err=%b want 1/0/0/0/0",
                     io.ready_o, io.icache_v_o, io.miss_cnt_o, io.ptag_v_o, io.order_err_o);
        end
        accept_en = 1'b1; yumi_pct = 100;
        drive_req(39'h5000);
        drain("post_reset");
    endtask

    initial begin
        retired_cnt = 0;
        accept_en = 1'b0; yumi_pct = 0; miss_pct = 0;
        saw_poison = 1'b0;
        test_reset();
        test_hits();
        test_miss();
        test_full();
        test_wrap();
        test_order_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
